// File: rtl/pos_input_ring_injector_if.sv
// Ring-node link bundle: upstream neighbour input, local injection input and
// the registered downstream ring output, plus the injected-packet counter.
interface pos_input_ring_injector_if #(
  parameter int GLOBAL_CELL_ID_WIDTH = 3,
  parameter int OFFSET_WIDTH         = 30,
  parameter int HOP_WIDTH            = 4,
  parameter int CNT_WIDTH            = 16
);
  logic                              i_up_valid;
  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] i_up_gcid;
  logic [3*OFFSET_WIDTH-1:0]         i_up_pos;
  logic [HOP_WIDTH-1:0]              i_up_hop;
  logic                              o_up_ready;
  logic                              i_inj_valid;
  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] i_inj_gcid;
  logic [3*OFFSET_WIDTH-1:0]         i_inj_pos;
  logic                              o_inj_ready;
  logic                              o_ring_valid;
  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_ring_gcid;
  logic [3*OFFSET_WIDTH-1:0]         o_ring_pos;
  logic [HOP_WIDTH-1:0]              o_ring_hop;
  logic                              i_ring_ready;
  logic [CNT_WIDTH-1:0]              o_inj_count;

  modport slave (
    input  i_up_valid, i_up_gcid, i_up_pos, i_up_hop,
    input  i_inj_valid, i_inj_gcid, i_inj_pos, i_ring_ready,
    output o_up_ready, o_inj_ready, o_ring_valid, o_ring_gcid,
    output o_ring_pos, o_ring_hop, o_inj_count
  );

  modport master (
    output i_up_valid, i_up_gcid, i_up_pos, i_up_hop,
    output i_inj_valid, i_inj_gcid, i_inj_pos, i_ring_ready,
    input  o_up_ready, o_inj_ready, o_ring_valid, o_ring_gcid,
    input  o_ring_pos, o_ring_hop, o_inj_count
  );
endinterface

// File: rtl/pos_input_ring_injector.sv
// Position input ring node: merges upstream through-traffic with local packets
// onto a single registered downstream link, with starvation-bounded injection.
module pos_input_ring_injector #(
  parameter int GLOBAL_CELL_ID_WIDTH = 3,
  parameter int OFFSET_WIDTH         = 30,
  parameter int HOP_WIDTH            = 4,
  parameter int NUM_RING_NODES       = 8,
  parameter int MAX_STARVE           = 4,
  parameter int CNT_WIDTH            = 16
) (
  input logic clk,
  input logic rst_n,
  pos_input_ring_injector_if.slave bus
);
  localparam int GW  = 3*GLOBAL_CELL_ID_WIDTH;
  localparam int PW  = 3*OFFSET_WIDTH;
  localparam int STW = $clog2(MAX_STARVE+1);
  localparam logic [STW-1:0]       STARVE_MAX = STW'(MAX_STARVE);
  localparam logic [HOP_WIDTH-1:0] INJ_HOP    = HOP_WIDTH'(NUM_RING_NODES-1);

  logic                 ring_valid_q, ring_valid_d;
  logic [GW-1:0]        ring_gcid_q, ring_gcid_d;
  logic [PW-1:0]        ring_pos_q, ring_pos_d;
  logic [HOP_WIDTH-1:0] ring_hop_q, ring_hop_d;
  logic [CNT_WIDTH-1:0] inj_count_q, inj_count_d;
  logic [STW-1:0]       starve_q, starve_d;
  logic                 load_en, force_inj, up_grant, inj_grant;

  // Grants are gated by rst_n so nothing is accepted while the node is held in reset.
  always_comb begin
    load_en   = !ring_valid_q || bus.i_ring_ready;
    force_inj = (starve_q == STARVE_MAX) && bus.i_inj_valid;
    up_grant  = 1'b0;
    inj_grant = 1'b0;
    if (rst_n && load_en) begin
      if (bus.i_up_valid && !force_inj) begin
        up_grant = 1'b1;
      end else if (bus.i_inj_valid) begin
        inj_grant = 1'b1;
      end
    end
  end

  always_comb begin
    ring_valid_d = ring_valid_q;
    ring_gcid_d  = ring_gcid_q;
    ring_pos_d   = ring_pos_q;
    ring_hop_d   = ring_hop_q;
    inj_count_d  = inj_count_q;
    starve_d     = starve_q;
    if (load_en) begin
      ring_valid_d = 1'b0;
    end
    if (up_grant) begin
      // An expired hop count is consumed here and never reaches the ring.
      ring_valid_d = (bus.i_up_hop != '0);
      ring_gcid_d  = bus.i_up_gcid;
      ring_pos_d   = bus.i_up_pos;
      ring_hop_d   = bus.i_up_hop - HOP_WIDTH'(1);
    end else if (inj_grant) begin
      ring_valid_d = 1'b1;
      ring_gcid_d  = bus.i_inj_gcid;
      ring_pos_d   = bus.i_inj_pos;
      ring_hop_d   = INJ_HOP;
      inj_count_d  = inj_count_q + CNT_WIDTH'(1);
    end
    if (!bus.i_inj_valid || inj_grant) begin
      starve_d = '0;
    end else if (up_grant && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_valid_q <= 1'b0;
      ring_gcid_q  <= '0;
      ring_pos_q   <= '0;
      ring_hop_q   <= '0;
      inj_count_q  <= '0;
      starve_q     <= '0;
    end else begin
      ring_valid_q <= ring_valid_d;
      ring_gcid_q  <= ring_gcid_d;
      ring_pos_q   <= ring_pos_d;
      ring_hop_q   <= ring_hop_d;
      inj_count_q  <= inj_count_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.o_up_ready   = up_grant;
  assign bus.o_inj_ready  = inj_grant;
  assign bus.o_ring_valid = ring_valid_q;
  assign bus.o_ring_gcid  = ring_gcid_q;
  assign bus.o_ring_pos   = ring_pos_q;
  assign bus.o_ring_hop   = ring_hop_q;
  assign bus.o_inj_count  = inj_count_q;
endmodule
